// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command assembler.
// Optional inter-byte timeout is enabled by UART_CMD_TIMEOUT_EN.
package uart_cmd_pkg;

  typedef enum logic {
    IDLE,
    WAIT_LO
  } asm_state_t;

  localparam int unsigned CMD_W = 16;
  localparam int unsigned DEFAULT_TIMEOUT_CYC = 2600000;

endpackage

// File: rtl/uart_cmd_timer.sv
// Inter-byte timeout counter: clear loads CYC-1, en counts down,
// expire flags the last allowed cycle. Used under UART_CMD_TIMEOUT_EN.
module uart_cmd_timer
  import uart_cmd_pkg::*;
#(
  parameter int unsigned CYC = DEFAULT_TIMEOUT_CYC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int unsigned TW = (CYC > 1) ? $clog2(CYC) : 1;
  localparam logic [TW-1:0] LOAD = TW'(CYC - 1);

  logic [TW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= LOAD;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - TW'(1);
    end
  end

  assign expire = en && (cnt == '0);

endmodule

// File: rtl/uart_cmd_assembler.sv
// Pairs two UART bytes (high first) into a 16-bit command.
// Define UART_CMD_TIMEOUT_EN to drop a stale high byte after TIMEOUT_CYC.
module uart_cmd_assembler
  import uart_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx_rdy,
  input  logic [7:0]       rx_data,
  output logic             clr_rx_rdy,
  input  logic             clr_cmd_rdy,
  output logic [CMD_W-1:0] cmd,
  output logic             cmd_rdy,
  output logic             timeout
);

  asm_state_t state, state_n;
  logic [7:0] hi_q;
  logic       hi_ld;
  logic       lo_ld;
  logic       to_hit;
  logic       tmr_expire;

`ifdef UART_CMD_TIMEOUT_EN
  uart_cmd_timer #(
    .CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (hi_ld),
    .en    (state == WAIT_LO),
    .expire(tmr_expire)
  );
`else
  assign tmr_expire = 1'b0;
`endif

  // Received data beats an expiring timer in the same cycle.
  always_comb begin
    state_n    = state;
    clr_rx_rdy = 1'b0;
    hi_ld      = 1'b0;
    lo_ld      = 1'b0;
    to_hit     = 1'b0;
    unique case (state)
      IDLE: begin
        if (rx_rdy) begin
          clr_rx_rdy = 1'b1;
          hi_ld      = 1'b1;
          state_n    = WAIT_LO;
        end
      end
      WAIT_LO: begin
        if (rx_rdy) begin
          clr_rx_rdy = 1'b1;
          lo_ld      = 1'b1;
          state_n    = IDLE;
        end else if (tmr_expire) begin
          to_hit  = 1'b1;
          state_n = IDLE;
        end
      end
    endcase
  end

  assign timeout = to_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      hi_q  <= 8'h00;
    end else begin
      state <= state_n;
      if (hi_ld) hi_q <= rx_data;
    end
  end

  // Set beats clear so a consumer ack never hides a fresh command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd     <= '0;
      cmd_rdy <= 1'b0;
    end else begin
      if (lo_ld) cmd <= {hi_q, rx_data};
      if (lo_ld) begin
        cmd_rdy <= 1'b1;
      end else if (hi_ld || clr_cmd_rdy) begin
        cmd_rdy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_assembler.sv
// Self-checking bench for uart_cmd_assembler.
// Timeout scenarios run when UART_CMD_TIMEOUT_EN is defined.
module tb_uart_cmd_assembler;

  localparam int unsigned TCYC = 100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_rdy;
  logic [7:0]  rx_data;
  logic        clr_rx_rdy;
  logic        clr_cmd_rdy;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        timeout;

  int pass_cnt = 0;
  int total = 0;
  int to_count = 0;

  logic [7:0]  m_hi;
  logic        m_have;
  logic [15:0] m_cmd;
  logic        m_rdy;

  uart_cmd_assembler #(
    .TIMEOUT_CYC(TCYC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_rdy     (rx_rdy),
    .rx_data    (rx_data),
    .clr_rx_rdy (clr_rx_rdy),
    .clr_cmd_rdy(clr_cmd_rdy),
    .cmd        (cmd),
    .cmd_rdy    (cmd_rdy),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    #1;
    if (timeout === 1'b1) to_count++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic do_reset();
    rst_n = 1'b0;
    rx_rdy = 1'b0;
    rx_data = 8'h00;
    clr_cmd_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    m_have = 1'b0;
    m_hi = 8'h00;
    m_cmd = 16'h0000;
    m_rdy = 1'b0;
  endtask

  // Receiver model: holds rdy until acked, drops it the edge after.
  task automatic send_byte(input logic [7:0] b, input logic wc,
                           output int acks);
    acks = 0;
    @(negedge clk);
    rx_data = b;
    rx_rdy = 1'b1;
    clr_cmd_rdy = wc;
    for (int i = 0; i < 16 && acks == 0; i++) begin
      #1;
      if (clr_rx_rdy === 1'b1) acks++;
      @(posedge clk);
      #1;
      if (acks == 0) @(negedge clk);
    end
    rx_rdy = 1'b0;
    clr_cmd_rdy = 1'b0;
    #1;
    if (clr_rx_rdy !== 1'b0) acks++;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr_cmd_rdy = 1'b1;
    @(posedge clk);
    #1 clr_cmd_rdy = 1'b0;
  endtask

  task automatic test_reset();
    int a;
    rst_n = 1'b0;
    rx_rdy = 1'b0;
    rx_data = 8'h00;
    clr_cmd_rdy = 1'b0;
    #1;
    total++;
    if (cmd !== 16'h0000 || cmd_rdy !== 1'b0 || timeout !== 1'b0 ||
        clr_rx_rdy !== 1'b0)
      $display("FAIL reset_init got cmd=%h rdy=%b to=%b clr=%b want 0000 0 0 0",
               cmd, cmd_rdy, timeout, clr_rx_rdy);
    else pass_cnt++;
    do_reset();
    send_byte(8'hC3, 1'b0, a);
    send_byte(8'h5A, 1'b0, a);
    total++;
    if (cmd !== 16'hC35A || cmd_rdy !== 1'b1)
      $display("FAIL reset_pre got %h/%b want c35a/1", cmd, cmd_rdy);
    else pass_cnt++;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    total++;
    if (cmd !== 16'h0000 || cmd_rdy !== 1'b0 || timeout !== 1'b0)
      $display("FAIL reset_async got cmd=%h rdy=%b to=%b want 0000 0 0",
               cmd, cmd_rdy, timeout);
    else pass_cnt++;
    @(posedge clk);
    #1 rst_n = 1'b1;
    send_byte(8'h11, 1'b0, a);
    @(negedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    send_byte(8'h22, 1'b0, a);
    send_byte(8'h33, 1'b0, a);
    total++;
    if (cmd !== 16'h2233 || cmd_rdy !== 1'b1)
      $display("FAIL reset_partial got %h/%b want 2233/1", cmd, cmd_rdy);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    int a;
    send_byte(8'hA5, 1'b0, a);
    total++;
    if (a !== 1) $display("FAIL basic_ack_hi got %0d want 1", a);
    else pass_cnt++;
    total++;
    if (cmd_rdy !== 1'b0)
      $display("FAIL basic_hi_clr got %b want 0", cmd_rdy);
    else pass_cnt++;
    send_byte(8'h3C, 1'b0, a);
    total++;
    if (a !== 1) $display("FAIL basic_ack_lo got %0d want 1", a);
    else pass_cnt++;
    total++;
    if (cmd !== 16'hA53C || cmd_rdy !== 1'b1)
      $display("FAIL basic_cmd got %h/%b want a53c/1", cmd, cmd_rdy);
    else pass_cnt++;
  endtask

  task automatic test_handshake();
    int a;
    pulse_clr();
    total++;
    if (cmd_rdy !== 1'b0 || cmd !== 16'hA53C)
      $display("FAIL hs_clear got %h/%b want a53c/0", cmd, cmd_rdy);
    else pass_cnt++;
    send_byte(8'h12, 1'b0, a);
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (cmd_rdy !== 1'b0 || cmd !== 16'hA53C)
      $display("FAIL hs_half got %h/%b want a53c/0", cmd, cmd_rdy);
    else pass_cnt++;
    send_byte(8'h34, 1'b0, a);
    total++;
    if (cmd !== 16'h1234 || cmd_rdy !== 1'b1)
      $display("FAIL hs_next got %h/%b want 1234/1", cmd, cmd_rdy);
    else pass_cnt++;
  endtask

  task automatic test_simultaneous();
    int a;
    send_byte(8'h01, 1'b0, a);
    send_byte(8'h77, 1'b1, a);
    total++;
    if (cmd !== 16'h0177 || cmd_rdy !== 1'b1)
      $display("FAIL simul got %h/%b want 0177/1", cmd, cmd_rdy);
    else pass_cnt++;
    @(posedge clk);
    #1;
    total++;
    if (cmd_rdy !== 1'b1)
      $display("FAIL simul_hold got %b want 1", cmd_rdy);
    else pass_cnt++;
  endtask

  task automatic test_random();
    int a;
    logic [7:0] b;
    logic wc;
    do_reset();
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        pulse_clr();
        m_rdy = 1'b0;
      end
      repeat ($urandom_range(0, 4)) @(posedge clk);
      b = 8'($urandom);
      wc = ($urandom_range(0, 3) == 0);
      send_byte(b, wc, a);
      if (!m_have) begin
        m_hi = b;
        m_have = 1'b1;
        m_rdy = 1'b0;
      end else begin
        m_cmd = {m_hi, b};
        m_rdy = 1'b1;
        m_have = 1'b0;
      end
      total++;
      if (a !== 1) $display("FAIL rnd_ack[%0d] got %0d want 1", n, a);
      else pass_cnt++;
      total++;
      if (cmd !== m_cmd)
        $display("FAIL rnd_cmd[%0d] got %h want %h", n, cmd, m_cmd);
      else pass_cnt++;
      total++;
      if (cmd_rdy !== m_rdy)
        $display("FAIL rnd_rdy[%0d] got %b want %b", n, cmd_rdy, m_rdy);
      else pass_cnt++;
    end
  endtask

`ifdef UART_CMD_TIMEOUT_EN
  task automatic test_timeout();
    int a;
    int hits;
    int hit_at;
    logic [15:0] prev;
    prev = cmd;
    send_byte(8'hFF, 1'b0, a);
    hits = 0;
    hit_at = -1;
    for (int k = 1; k <= TCYC + 10; k++) begin
      @(negedge clk);
      #1;
      if (timeout === 1'b1) begin
        hits++;
        hit_at = k;
      end
    end
    total++;
    if (hits !== 1 || hit_at !== int'(TCYC))
      $display("FAIL to_pulse got %0d pulses at %0d want 1 at %0d",
               hits, hit_at, TCYC);
    else pass_cnt++;
    total++;
    if (cmd !== prev || cmd_rdy !== 1'b0)
      $display("FAIL to_hold got %h/%b want %h/0", cmd, cmd_rdy, prev);
    else pass_cnt++;
    send_byte(8'h0A, 1'b0, a);
    send_byte(8'h0B, 1'b0, a);
    total++;
    if (cmd !== 16'h0A0B || cmd_rdy !== 1'b1)
      $display("FAIL to_resync got %h/%b want 0a0b/1", cmd, cmd_rdy);
    else pass_cnt++;
  endtask

  task automatic test_race();
    int a;
    int c0;
    send_byte(8'h66, 1'b0, a);
    repeat (TCYC - 1) @(posedge clk);
    c0 = to_count;
    send_byte(8'h55, 1'b0, a);
    repeat (3) @(posedge clk);
    #2;
    total++;
    if (to_count !== c0)
      $display("FAIL race_to got %0d pulses want 0", to_count - c0);
    else pass_cnt++;
    total++;
    if (cmd !== 16'h6655 || cmd_rdy !== 1'b1 || a !== 1)
      $display("FAIL race_cmd got %h/%b ack %0d want 6655/1 ack 1",
               cmd, cmd_rdy, a);
    else pass_cnt++;
  endtask
`else
  task automatic test_long_gap();
    int a;
    send_byte(8'h9D, 1'b0, a);
    repeat (10000) @(posedge clk);
    send_byte(8'hE4, 1'b0, a);
    total++;
    if (cmd !== 16'h9DE4 || cmd_rdy !== 1'b1)
      $display("FAIL gap_cmd got %h/%b want 9de4/1", cmd, cmd_rdy);
    else pass_cnt++;
    total++;
    if (to_count !== 0)
      $display("FAIL gap_timeout got %0d pulses want 0", to_count);
    else pass_cnt++;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_handshake();
    test_simultaneous();
    test_random();
`ifdef UART_CMD_TIMEOUT_EN
    test_timeout();
    test_race();
`else
    test_long_gap();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
